sprite_blitter: RTL and testbench
=================================

SPRITE_BLITTER -- requirements
Module: sprite_blitter

Interface
REQ-001 Parameter FB_WIDTH, default 320; framebuffer width in pixels.
REQ-002 Parameter FB_HEIGHT, default 240; framebuffer height in pixels.
REQ-003 Parameter TRANSPARENT, default 16'hFFFF; RGB565 colour key, never written.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 start  input  1  request a blit; sampled only in IDLE.
REQ-007 origin_x  input  9  framebuffer column of sprite pixel (0,0).
REQ-008 origin_y  input  9  framebuffer row of sprite pixel (0,0).
REQ-009 sprite_width  input  9  sprite column count, from sprite ROM.
REQ-010 sprite_height  input  9  sprite row count, from sprite ROM.
REQ-011 sprite_pixel  output  17  sprite ROM index, row*width+col.
REQ-012 sprite_color  input  16  RGB565 from ROM, combinational on sprite_pixel, same cycle.
REQ-013 fb_addr  output  17  framebuffer write address.
REQ-014 fb_data  output  16  framebuffer write data.
REQ-015 fb_we  output  1  write valid; held until fb_ready.
REQ-016 fb_ready  input  1  framebuffer accepts write this cycle when fb_we&fb_ready.
REQ-017 busy  output  1  high from cycle after accepted start until done.
REQ-018 done  output  1  one-cycle pulse at blit completion.

Function
REQ-019 FSM states IDLE, READ, WRITE, DONE; reset state IDLE.
REQ-020 IDLE: start=1 latches origin_x/y, sprite_width/height, clears col/row, goes READ; if latched width or height is 0, goes DONE instead.
REQ-021 start while not IDLE is ignored; no queuing.
REQ-022 READ (1 cycle): sprite_pixel=row*width+col; register sprite_color; pixel is skipped if colour==TRANSPARENT or origin_x+col>=FB_WIDTH or origin_y+row>=FB_HEIGHT.
REQ-023 READ, not skipped: go WRITE with fb_addr=(origin_y+row)*FB_WIDTH+origin_x+col (computed 18-bit, truncated to 17), fb_data=registered colour.
REQ-024 READ, skipped: advance counters, stay READ or go DONE; no write, exactly 1 cycle per skipped pixel.
REQ-025 WRITE: fb_we=1, fb_addr/fb_data stable until fb_ready=1; on handshake advance counters, go READ or DONE.
REQ-026 Counter advance: col+1; at col==width-1, col=0 and row+1; after col==width-1 and row==height-1, go DONE.
REQ-027 Pixel order raster: row-major, row 0 first, col 0 first.
REQ-028 Throughput: 2 cycles per written pixel with fb_ready held high; 1 cycle per skipped pixel.
REQ-029 DONE (1 cycle): done=1, busy=0 next cycle, return IDLE; start in the DONE cycle is ignored.
REQ-030 sprite_pixel is 0 outside READ; fb_we is 0 outside WRITE.

Reset
REQ-031 rst=1 at any clock edge: state IDLE, col=row=0, busy=0, done=0, fb_we=0, fb_addr=0, fb_data=0, sprite_pixel=0.
REQ-032 Reset mid-blit aborts without done pulse; writes already accepted are not undone; the pending write is dropped.

Structure
REQ-033 Shared package holds the state enum, RGB565 colour type, and default TRANSPARENT/FB_WIDTH/FB_HEIGHT constants.
REQ-034 One sub-module, fb_addr_calc: combinational (y*FB_WIDTH+x) plus clip flag; everything else inline.

Verification
REQ-035 Scenario 1: 2x2 sprite colours {1111,2222,3333,4444}, origin (10,5), fb_ready=1 -> writes at 1610,1611,1930,1931 in order, done pulse 9 cycles after start.
REQ-036 Scenario 2: same sprite, colour 2222 replaced with FFFF -> 3 writes only, skipped slot 1 cycle, done 8 cycles after start.
REQ-037 Scenario 3: 4x1 sprite at origin (318,0) -> writes at 318,319 only; cols 2,3 clipped, no fb_we.
REQ-038 Scenario 4: fb_ready low 3 cycles on first write -> fb_we, fb_addr, fb_data held stable 4 cycles; no pixel lost or duplicated.
REQ-039 Scenario 5: sprite_width=0 -> no writes, done pulses 2 cycles after start; start during busy -> no second blit.
REQ-040 Scenario 6: rst asserted during second WRITE of a 29x32 sprite -> next cycle fb_we=0, busy=0, no done; fresh start then blits normally.

Source files
------------

// File: rtl/sprite_blitter_pkg.sv
// Shared types and defaults for the sprite blitter: FSM states, RGB565 colour
// type and framebuffer geometry.
package sprite_blitter_pkg;
    localparam int COORD_W = 9;
    localparam int ADDR_W  = 17;

    localparam int DEF_FB_WIDTH  = 320;
    localparam int DEF_FB_HEIGHT = 240;

    typedef logic [15:0] rgb565_t;

    localparam rgb565_t DEF_TRANSPARENT = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE,
        ST_DONE
    } blit_state_t;
endpackage

// File: rtl/sprite_blitter_if.sv
// Command, sprite ROM and framebuffer write signals of the blitter.
// master = host/system side, slave = blitter.
interface sprite_blitter_if;
    import sprite_blitter_pkg::*;

    logic               start;
    logic [COORD_W-1:0] origin_x;
    logic [COORD_W-1:0] origin_y;
    logic [COORD_W-1:0] sprite_width;
    logic [COORD_W-1:0] sprite_height;
    logic [ADDR_W-1:0]  sprite_pixel;
    rgb565_t            sprite_color;
    logic [ADDR_W-1:0]  fb_addr;
    rgb565_t            fb_data;
    logic               fb_we;
    logic               fb_ready;
    logic               busy;
    logic               done;

    modport master (
        output start, origin_x, origin_y, sprite_width, sprite_height,
               sprite_color, fb_ready,
        input  sprite_pixel, fb_addr, fb_data, fb_we, busy, done
    );

    modport slave (
        input  start, origin_x, origin_y, sprite_width, sprite_height,
               sprite_color, fb_ready,
        output sprite_pixel, fb_addr, fb_data, fb_we, busy, done
    );
endinterface

// File: rtl/sprite_blitter_fb_addr_calc.sv
// Framebuffer linear address (y*FB_WIDTH + x, truncated to 17 bits) and
// off-screen clip flag for one target pixel.
module fb_addr_calc
    import sprite_blitter_pkg::*;
#(
    parameter int FB_WIDTH  = DEF_FB_WIDTH,
    parameter int FB_HEIGHT = DEF_FB_HEIGHT
) (
    input  logic [COORD_W:0]   x,
    input  logic [COORD_W:0]   y,
    output logic [ADDR_W-1:0]  addr,
    output logic               clip
);
    localparam logic [COORD_W:0] X_LIM = 10'(FB_WIDTH);
    localparam logic [COORD_W:0] Y_LIM = 10'(FB_HEIGHT);

    assign addr = ADDR_W'(y) * ADDR_W'(FB_WIDTH) + ADDR_W'(x);
    assign clip = (x >= X_LIM) || (y >= Y_LIM);
endmodule

// File: rtl/sprite_blitter.sv
// Sprite blitter: copies a sprite from ROM into the framebuffer in raster
// order, skipping colour-keyed and off-screen pixels.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | waiting for start; latches origin and sprite size
// ST_READ  | fetch one sprite pixel, decide write or skip
// ST_WRITE | fb_we held with stable addr/data until fb_ready
// ST_DONE  | one-cycle done pulse, back to idle
module sprite_blitter
    import sprite_blitter_pkg::*;
#(
    parameter int      FB_WIDTH    = DEF_FB_WIDTH,
    parameter int      FB_HEIGHT   = DEF_FB_HEIGHT,
    parameter rgb565_t TRANSPARENT = DEF_TRANSPARENT
) (
    input  logic             clk,
    input  logic             rst,
    sprite_blitter_if.slave  bus
);
    blit_state_t        state, state_n;
    logic [COORD_W-1:0] ox, oy, w, h;
    logic [COORD_W-1:0] col, row;
    rgb565_t            color_q;
    logic [ADDR_W-1:0]  addr_q;

    logic [COORD_W:0]   px, py;
    logic [ADDR_W-1:0]  pix_addr;
    logic [ADDR_W-1:0]  rom_idx;
    logic               clip, empty, last, skip;
    logic               latch, load, advance;

    assign px = {1'b0, ox} + {1'b0, col};
    assign py = {1'b0, oy} + {1'b0, row};

    fb_addr_calc #(
        .FB_WIDTH  (FB_WIDTH),
        .FB_HEIGHT (FB_HEIGHT)
    ) u_addr_calc (
        .x    (px),
        .y    (py),
        .addr (pix_addr),
        .clip (clip)
    );

    assign rom_idx = ADDR_W'(row) * ADDR_W'(w) + ADDR_W'(col);
    assign empty   = (w == '0) || (h == '0);
    assign last    = (col == w - 9'd1) && (row == h - 9'd1);
    assign skip    = (bus.sprite_color == TRANSPARENT) || clip;

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_n;
    end

    // Empty sprites are resolved in the first READ cycle from the latched
    // size, so done follows start by two cycles with no fetch or write.
    always_comb begin
        state_n = state;
        latch   = 1'b0;
        load    = 1'b0;
        advance = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    latch   = 1'b1;
                    state_n = ST_READ;
                end
            end
            ST_READ: begin
                if (empty) begin
                    state_n = ST_DONE;
                end else if (skip) begin
                    advance = 1'b1;
                    state_n = last ? ST_DONE : ST_READ;
                end else begin
                    load    = 1'b1;
                    state_n = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (bus.fb_ready) begin
                    advance = 1'b1;
                    state_n = last ? ST_DONE : ST_READ;
                end
            end
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ox      <= '0;
            oy      <= '0;
            w       <= '0;
            h       <= '0;
            col     <= '0;
            row     <= '0;
            color_q <= '0;
            addr_q  <= '0;
        end else begin
            if (latch) begin
                ox  <= bus.origin_x;
                oy  <= bus.origin_y;
                w   <= bus.sprite_width;
                h   <= bus.sprite_height;
                col <= '0;
                row <= '0;
            end
            if (load) begin
                color_q <= bus.sprite_color;
                addr_q  <= pix_addr;
            end
            if (advance) begin
                if (col == w - 9'd1) begin
                    col <= '0;
                    row <= row + 9'd1;
                end else begin
                    col <= col + 9'd1;
                end
            end
        end
    end

    assign bus.sprite_pixel = (state == ST_READ) ? rom_idx : '0;
    assign bus.fb_addr      = addr_q;
    assign bus.fb_data      = color_q;
    assign bus.fb_we        = (state == ST_WRITE);
    assign bus.busy         = (state != ST_IDLE);
    assign bus.done         = (state == ST_DONE);
endmodule

// File: tb/tb_sprite_blitter.sv
// Self-checking bench for sprite_blitter: directed scenarios plus randomized
// blits compared against a raster-order reference model.
module tb_sprite_blitter;
    import sprite_blitter_pkg::*;

    typedef struct packed {
        logic [16:0] addr;
        logic [15:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sprite_blitter_if bus();

    sprite_blitter #(
        .FB_WIDTH    (320),
        .FB_HEIGHT   (240),
        .TRANSPARENT (16'hFFFF)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [15:0] rom [0:1023];
    assign bus.sprite_color = rom[bus.sprite_pixel[9:0]];

    int  checks   = 0;
    int  failures = 0;
    wr_t exp_q[$];
    wr_t got_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference: walk the sprite row-major and list the writes that survive
    // colour key and screen clipping; cost is 2 cycles per write, 1 per skip.
    task automatic model_blit(input int ox, input int oy, input int w, input int h,
                              output int done_cyc);
        wr_t e;
        exp_q.delete();
        if (w == 0 || h == 0) begin
            done_cyc = 2;
            return;
        end
        done_cyc = 1;
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                int x, y, idx;
                x   = ox + c;
                y   = oy + r;
                idx = r * w + c;
                if (rom[idx] != 16'hFFFF && x < 320 && y < 240) begin
                    e.addr = 17'(y * 320 + x);
                    e.data = rom[idx];
                    exp_q.push_back(e);
                    done_cyc += 2;
                end else begin
                    done_cyc += 1;
                end
            end
        end
    endtask

    task automatic run_blit(input string tag, input int ox, input int oy, input int w,
                            input int h, input int stall_first, input bit rand_ready,
                            input int restart_cyc, input int rst_cyc);
        int exp_done, cyc, stalls, done_at, done_cnt, stall_left, idle_busy;
        bit held;
        logic [16:0] ha;
        logic [15:0] hd;
        model_blit(ox, oy, w, h, exp_done);
        got_q.delete();
        @(negedge clk);
        bus.origin_x      = 9'(ox);
        bus.origin_y      = 9'(oy);
        bus.sprite_width  = 9'(w);
        bus.sprite_height = 9'(h);
        bus.fb_ready      = 1'b1;
        bus.start         = 1'b1;
        cyc = 0; stalls = 0; done_at = -1; done_cnt = 0;
        stall_left = stall_first; held = 0; ha = '0; hd = '0;
        while (cyc < 4000) begin
            @(negedge clk);
            cyc++;
            bus.start = 1'b0;
            if (cyc == 1) check({tag, " busy_after_start"}, bus.busy, 1);
            if (cyc == restart_cyc) begin
                bus.start        = 1'b1;
                bus.origin_x     = 9'(ox + 7);
                bus.sprite_width = 9'(w + 1);
            end
            if (cyc == rst_cyc) begin
                check({tag, " we_before_rst"}, bus.fb_we, 1);
                bus.fb_ready = 1'b1;
                rst = 1'b1;
                break;
            end
            if (held) begin
                check({tag, " hold_we"}, bus.fb_we, 1);
                check({tag, " hold_addr"}, bus.fb_addr, ha);
                check({tag, " hold_data"}, bus.fb_data, hd);
            end
            held = 0;
            if (bus.fb_we) begin
                check({tag, " pixel_idx_zero_in_write"}, bus.sprite_pixel, 0);
                if (stall_left > 0) begin
                    bus.fb_ready = 1'b0;
                    stall_left--;
                end else if (rand_ready) begin
                    bus.fb_ready = ($urandom_range(0, 2) != 0);
                end else begin
                    bus.fb_ready = 1'b1;
                end
                if (bus.fb_ready) begin
                    got_q.push_back({bus.fb_addr, bus.fb_data});
                end else begin
                    stalls++;
                    held = 1;
                    ha = bus.fb_addr;
                    hd = bus.fb_data;
                end
            end
            if (bus.done) begin
                done_cnt++;
                if (done_at < 0) done_at = cyc;
            end
            if (done_at >= 0 && cyc > done_at) break;
        end

        if (rst_cyc > 0) begin
            @(negedge clk);
            check({tag, " rst_we"}, bus.fb_we, 0);
            check({tag, " rst_busy"}, bus.busy, 0);
            check({tag, " rst_done"}, bus.done, 0);
            check({tag, " rst_addr"}, bus.fb_addr, 0);
            check({tag, " rst_data"}, bus.fb_data, 0);
            check({tag, " rst_pixel"}, bus.sprite_pixel, 0);
            rst = 1'b0;
            check({tag, " rst_writes_kept"}, got_q.size(), 1);
            if (got_q.size() > 0) check({tag, " rst_first_write"}, got_q[0], exp_q[0]);
            done_cnt = 0; idle_busy = 0;
            repeat (5) begin
                @(negedge clk);
                if (bus.done) done_cnt++;
                if (bus.busy) idle_busy++;
            end
            check({tag, " no_done_after_rst"}, done_cnt, 0);
            check({tag, " idle_after_rst"}, idle_busy, 0);
            return;
        end

        check({tag, " done_cycle"}, done_at, exp_done + stalls);
        check({tag, " done_one_pulse"}, done_cnt, 1);
        check({tag, " busy_low_after_done"}, bus.busy, 0);
        check({tag, " write_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            check($sformatf("%s write%0d", tag, i), got_q[i], exp_q[i]);
        if (restart_cyc > 0) begin
            idle_busy = 0;
            repeat (4) begin
                @(negedge clk);
                if (bus.busy || bus.fb_we || bus.done) idle_busy++;
            end
            check({tag, " no_second_blit"}, idle_busy, 0);
        end
    endtask

    initial begin
        int ox, oy, w, h;
        for (int i = 0; i < 1024; i++) rom[i] = 16'h0000;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.origin_x = '0;
        bus.origin_y = '0;
        bus.sprite_width = '0;
        bus.sprite_height = '0;
        bus.fb_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("reset fb_we", bus.fb_we, 0);
        check("reset busy", bus.busy, 0);
        check("reset done", bus.done, 0);
        check("reset fb_addr", bus.fb_addr, 0);
        check("reset fb_data", bus.fb_data, 0);
        check("reset sprite_pixel", bus.sprite_pixel, 0);
        rst = 1'b0;

        rom[0] = 16'h1111; rom[1] = 16'h2222; rom[2] = 16'h3333; rom[3] = 16'h4444;
        run_blit("s1_2x2", 10, 5, 2, 2, 0, 0, -1, -1);

        rom[1] = 16'hFFFF;
        run_blit("s2_keyed", 10, 5, 2, 2, 0, 0, -1, -1);

        rom[0] = 16'h0A0A; rom[1] = 16'h0B0B; rom[2] = 16'h0C0C; rom[3] = 16'h0D0D;
        run_blit("s3_clip", 318, 0, 4, 1, 0, 0, -1, -1);

        rom[0] = 16'h1111; rom[1] = 16'h2222; rom[2] = 16'h3333; rom[3] = 16'h4444;
        run_blit("s4_stall", 10, 5, 2, 2, 3, 0, -1, -1);

        run_blit("s5_zero_w", 10, 5, 0, 2, 0, 0, 1, -1);
        run_blit("s5_start_busy", 10, 5, 2, 2, 0, 0, 4, -1);

        for (int i = 0; i < 928; i++) begin
            rom[i] = 16'($urandom);
            if (rom[i] == 16'hFFFF) rom[i] = 16'h0000;
        end
        run_blit("s6_reset", 0, 0, 29, 32, 0, 0, -1, 4);
        run_blit("s6_fresh", 0, 0, 29, 32, 0, 1, -1, -1);

        for (int n = 0; n < 8; n++) begin
            w  = $urandom_range(0, 8);
            h  = $urandom_range(0, 8);
            ox = (n % 2 == 0) ? $urandom_range(300, 330) : $urandom_range(0, 200);
            oy = (n % 3 == 0) ? $urandom_range(230, 250) : $urandom_range(0, 200);
            for (int i = 0; i < 64; i++)
                rom[i] = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
            run_blit($sformatf("rand%0d", n), ox, oy, w, h, 0, 1, -1, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
